// File: rtl/servo_pwm_bank.sv
// Multi-channel 50 Hz servo pulse generator with clamped targets, frame-synchronous
// update and per-channel command watchdog. Define SERVO_SLEW_LIMIT_EN for per-frame slew limiting.
module servo_pwm_bank #(
  parameter int NUM_CH         = 2,
  parameter int CNT_W          = 18,
  parameter int FRAME_TICKS    = 200000,
  parameter int MIN_TICKS      = 10000,
  parameter int MAX_TICKS      = 20000,
  parameter int NEUTRAL_TICKS  = 15000,
  parameter int SLEW_STEP      = 50,
  parameter int TIMEOUT_FRAMES = 25,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              SYSCLK,
  input  logic              NSYSRESET,
  input  logic              enable,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              frame_start,
  output logic [NUM_CH-1:0] timeout
);

  localparam int WD_W = (TIMEOUT_FRAMES > 0) ? $clog2(TIMEOUT_FRAMES + 1) : 1;
  localparam logic [WD_W-1:0]  WD_MAX      = WD_W'(TIMEOUT_FRAMES);
  localparam logic [CNT_W-1:0] NEUTRAL_W   = CNT_W'(NEUTRAL_TICKS);
  localparam logic [CNT_W-1:0] LAST_TICK_W = CNT_W'(FRAME_TICKS - 1);

  logic [CNT_W-1:0]  cnt_r;
  logic              frame_start_r;
  logic [NUM_CH-1:0] pwm_r;
  logic [NUM_CH-1:0] timeout_r;
  logic [CNT_W-1:0]  target_r [NUM_CH];
  logic [CNT_W-1:0]  active_r [NUM_CH];
  logic [WD_W-1:0]   wd_r     [NUM_CH];

  logic              frame_tick_s;
  logic [CNT_W-1:0]  wr_clamp_s;
  logic [NUM_CH-1:0] wr_hit_s;
  logic [WD_W-1:0]   wd_inc_s [NUM_CH];
  logic [CNT_W-1:0]  next_s   [NUM_CH];

  function automatic logic [CNT_W-1:0] clamp_width(input logic [CNT_W-1:0] d);
    logic [CNT_W-1:0] r;
    if (d < CNT_W'(MIN_TICKS)) r = CNT_W'(MIN_TICKS);
    else if (d > CNT_W'(MAX_TICKS)) r = CNT_W'(MAX_TICKS);
    else r = d;
    return r;
  endfunction

`ifdef SERVO_SLEW_LIMIT_EN
  // Differences are taken larger-minus-smaller so they never wrap.
  function automatic logic [CNT_W-1:0] slew_width(input logic [CNT_W-1:0] act,
                                                  input logic [CNT_W-1:0] tgt);
    logic [CNT_W-1:0] step;
    logic [CNT_W-1:0] r;
    step = CNT_W'(SLEW_STEP);
    if (tgt > act) begin
      if ((tgt - act) <= step) r = tgt;
      else r = act + step;
    end else begin
      if ((act - tgt) <= step) r = tgt;
      else r = act - step;
    end
    return r;
  endfunction
`endif

  // Frame tick, write decode, watchdog increment and next active width per channel.
  always_comb begin
    frame_tick_s = enable && (cnt_r == LAST_TICK_W);
    wr_clamp_s   = clamp_width(wr_data);
    wr_hit_s     = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit_s[i] = wr_en && (wr_ch == CH_W'(i));
      if (wd_r[i] == WD_MAX) wd_inc_s[i] = wd_r[i];
      else wd_inc_s[i] = wd_r[i] + WD_W'(1);
`ifdef SERVO_SLEW_LIMIT_EN
      next_s[i] = slew_width(active_r[i], target_r[i]);
`else
      next_s[i] = target_r[i];
`endif
    end
  end

  // Frame counter and registered frame_start / pulse outputs.
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      cnt_r         <= {CNT_W{1'b0}};
      frame_start_r <= 1'b0;
      pwm_r         <= {NUM_CH{1'b0}};
    end else begin
      if (!enable || frame_tick_s) cnt_r <= {CNT_W{1'b0}};
      else cnt_r <= cnt_r + CNT_W'(1);
      frame_start_r <= enable && (cnt_r == {CNT_W{1'b0}});
      for (int i = 0; i < NUM_CH; i++) begin
        pwm_r[i] <= enable && (cnt_r < active_r[i]);
      end
    end
  end

  // Per-channel target, watchdog and active width; a write beats the watchdog.
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      timeout_r <= {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
        target_r[i] <= NEUTRAL_W;
        active_r[i] <= NEUTRAL_W;
        wd_r[i]     <= {WD_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_hit_s[i]) begin
          target_r[i]  <= wr_clamp_s;
          wd_r[i]      <= {WD_W{1'b0}};
          timeout_r[i] <= 1'b0;
        end else if (frame_tick_s && (TIMEOUT_FRAMES != 0)) begin
          wd_r[i] <= wd_inc_s[i];
          if (wd_inc_s[i] == WD_MAX) begin
            target_r[i]  <= NEUTRAL_W;
            timeout_r[i] <= 1'b1;
          end
        end
        if (frame_tick_s) active_r[i] <= next_s[i];
      end
    end
  end

  assign pwm_out     = pwm_r;
  assign frame_start = frame_start_r;
  assign timeout     = timeout_r;

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Directed bench for servo_pwm_bank; expectations follow SERVO_SLEW_LIMIT_EN when defined.
// A second 3-channel instance receives only an out-of-range channel write.
module tb_servo_pwm_bank;

  logic        SYSCLK = 1'b0;
  logic        NSYSRESET;
  logic        enable;
  logic        wr_en;
  logic [0:0]  wr_ch;
  logic [17:0] wr_data;
  logic [1:0]  pwm_out;
  logic        frame_start;
  logic [1:0]  timeout;

  logic        wr_en3;
  logic [1:0]  wr_ch3;
  logic [17:0] wr_data3;
  logic [2:0]  pwm3;
  logic        frame_start3;
  logic [2:0]  timeout3;

  int checks   = 0;
  int failures = 0;
  int w0, w1, n0, n1, n2, waits;
  logic [1:0] pwm_fs, to_fs;
  logic [2:0] pwm3_fs, to3_fs;

`ifdef SERVO_SLEW_LIMIT_EN
  int exp0 [14] = '{150, 150, 160, 170, 180, 170, 160, 150, 160, 170, 180, 190, 200, 200};
  int exp1 [14] = '{150, 150, 150, 140, 150, 160, 170, 160, 150, 150, 150, 150, 150, 150};
`else
  int exp0 [14] = '{150, 150, 180, 180, 180, 150, 120, 120, 180, 200, 200, 200, 200, 200};
  int exp1 [14] = '{150, 150, 150, 100, 200, 200, 200, 150, 150, 150, 150, 150, 150, 150};
`endif
  int exp_to   [14] = '{0, 0, 0, 0, 1, 1, 2, 2, 2, 2, 2, 2, 2, 2};
  int exp_to3  [14] = '{0, 0, 0, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7};
  int exp_wait [14] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};

  servo_pwm_bank #(
    .NUM_CH(2), .CNT_W(18), .FRAME_TICKS(1000), .MIN_TICKS(100), .MAX_TICKS(200),
    .NEUTRAL_TICKS(150), .SLEW_STEP(10), .TIMEOUT_FRAMES(3)
  ) dut (
    .SYSCLK(SYSCLK), .NSYSRESET(NSYSRESET), .enable(enable), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_data(wr_data), .pwm_out(pwm_out), .frame_start(frame_start),
    .timeout(timeout)
  );

  servo_pwm_bank #(
    .NUM_CH(3), .CNT_W(18), .FRAME_TICKS(1000), .MIN_TICKS(100), .MAX_TICKS(200),
    .NEUTRAL_TICKS(150), .SLEW_STEP(10), .TIMEOUT_FRAMES(3)
  ) dut3 (
    .SYSCLK(SYSCLK), .NSYSRESET(NSYSRESET), .enable(enable), .wr_en(wr_en3),
    .wr_ch(wr_ch3), .wr_data(wr_data3), .pwm_out(pwm3), .frame_start(frame_start3),
    .timeout(timeout3)
  );

  always #5 SYSCLK = ~SYSCLK;

  task automatic check(input string tag, input int idx, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, idx, obs, exp);
    end
  endtask

  // Waits (bounded) for frame_start, optionally writes on its first cycle, then
  // counts high cycles over one full 1000-cycle frame and checks the results.
  task automatic run_frame(input int idx, input bit do_wr, input logic [0:0] ch,
                           input logic [17:0] data, input bit do_wr3);
    waits = 0;
    while (frame_start !== 1'b1 && waits < 2000) begin
      @(negedge SYSCLK);
      waits++;
    end
    check("frame_wait", idx, 32'(waits), 32'(exp_wait[idx]));
    pwm_fs = pwm_out; to_fs = timeout; pwm3_fs = pwm3; to3_fs = timeout3;
    w0 = 0; w1 = 0; n0 = 0; n1 = 0; n2 = 0;
    if (do_wr) begin wr_en = 1'b1; wr_ch = ch; wr_data = data; end
    if (do_wr3) begin wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_data3 = 18'd180; end
    for (int j = 0; j < 1000; j++) begin
      if (pwm_out[0]) w0++;
      if (pwm_out[1]) w1++;
      if (pwm3[0]) n0++;
      if (pwm3[1]) n1++;
      if (pwm3[2]) n2++;
      @(negedge SYSCLK);
      wr_en = 1'b0; wr_en3 = 1'b0;
    end
    check("width_ch0", idx, 32'(w0), 32'(exp0[idx]));
    check("width_ch1", idx, 32'(w1), 32'(exp1[idx]));
    check("pwm_at_frame_start", idx, 32'(pwm_fs), 32'd3);
    check("timeout", idx, 32'(to_fs), 32'(exp_to[idx]));
    check("dut3_widths", idx, 32'({n0[7:0], n1[7:0], n2[7:0]}), {8'd0, 8'd150, 8'd150, 8'd150});
    check("dut3_pwm_at_frame_start", idx, 32'(pwm3_fs), 32'd7);
    check("dut3_timeout", idx, 32'(to3_fs), 32'(exp_to3[idx]));
  endtask

  initial begin
    NSYSRESET = 1'b0; enable = 1'b0;
    wr_en = 1'b0; wr_ch = 1'b0; wr_data = 18'd0;
    wr_en3 = 1'b0; wr_ch3 = 2'd0; wr_data3 = 18'd0;
    repeat (3) @(negedge SYSCLK);
    check("reset_pwm", 0, 32'(pwm_out), 32'd0);
    NSYSRESET = 1'b1;
    repeat (4) @(negedge SYSCLK);
    check("idle_pwm", 0, 32'(pwm_out), 32'd0);
    check("idle_frame_start", 0, 32'(frame_start), 32'd0);
    check("idle_timeout", 0, 32'(timeout), 32'd0);
    check("idle_dut3_pwm", 0, 32'(pwm3), 32'd0);

    enable = 1'b1;
    run_frame(0, 1'b0, 1'b0, 18'd0,   1'b0);
    run_frame(1, 1'b1, 1'b0, 18'd180, 1'b0);
    run_frame(2, 1'b1, 1'b1, 18'd50,  1'b0);
    run_frame(3, 1'b1, 1'b1, 18'd300, 1'b0);
    run_frame(4, 1'b0, 1'b0, 18'd0,   1'b1);
    run_frame(5, 1'b1, 1'b0, 18'd120, 1'b0);
    run_frame(6, 1'b0, 1'b0, 18'd0,   1'b0);
    run_frame(7, 1'b1, 1'b0, 18'd180, 1'b0);

    // Drop enable on the cycle the counter holds 50, mid-pulse on both channels.
    repeat (49) @(negedge SYSCLK);
    check("pre_drop_pwm", 8, 32'(pwm_out), 32'd3);
    enable = 1'b0;
    @(negedge SYSCLK);
    check("drop_pwm", 8, 32'(pwm_out), 32'd0);
    check("drop_frame_start", 8, 32'(frame_start), 32'd0);
    repeat (5) @(negedge SYSCLK);
    check("held_pwm", 8, 32'(pwm_out), 32'd0);
    check("held_dut3_pwm", 8, 32'(pwm3), 32'd0);
    enable = 1'b1;
    run_frame(8, 1'b1, 1'b0, 18'd200, 1'b0);
    for (int k = 9; k < 14; k++) run_frame(k, 1'b1, 1'b0, 18'd200, 1'b0);

    // Asynchronous reset between clock edges while pulses are high.
    repeat (10) @(negedge SYSCLK);
    check("pre_reset_pwm", 14, 32'(pwm_out), 32'd3);
    #2 NSYSRESET = 1'b0;
    #1;
    check("async_reset_pwm", 14, 32'(pwm_out), 32'd0);
    check("async_reset_timeout", 14, 32'(timeout), 32'd0);
    check("async_reset_dut3_timeout", 14, 32'(timeout3), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/servo_pwm_bank.md
# servo_pwm_bank

Parametrised multi-channel continuous-rotation servo PWM generator for the Segway motor path. It is driven by the MSS fabric interface and produces one standard 50 Hz servo pulse per channel. Each channel has a clamped target pulse width, frame-synchronous update and a per-channel command watchdog that returns the servo to neutral (stop) when the firmware goes silent. Optional slew limiting ramps pulse width between frames.

## Interface
Parameters:
- NUM_CH, 2: number of servo channels (1..16).
- CNT_W, 18: width of tick counters and pulse-width values.
- FRAME_TICKS, 200000: SYSCLK cycles per frame (20 ms at 10 MHz).
- MIN_TICKS, 10000: minimum pulse width (1.0 ms).
- MAX_TICKS, 20000: maximum pulse width (2.0 ms).
- NEUTRAL_TICKS, 15000: stop pulse width (1.5 ms).
- SLEW_STEP, 50: maximum per-frame change of active width (slew build only).
- TIMEOUT_FRAMES, 25: frames without a write before forcing neutral; 0 disables the watchdog.

Ports:
- SYSCLK  in  1  system clock; all logic is on its rising edge.
- NSYSRESET  in  1  asynchronous active-low reset.
- enable  in  1  run frames; low forces outputs low and holds the frame counter.
- wr_en  in  1  single-cycle write strobe.
- wr_ch  in  $clog2(NUM_CH) (min 1)  channel index for the write.
- wr_data  in  CNT_W  requested pulse width in ticks.
- pwm_out  out  NUM_CH  servo pulse per channel.
- frame_start  out  1  one-cycle pulse aligned to the first cycle of each frame.
- timeout  out  NUM_CH  per-channel watchdog-expired flag.

## Operation
- Reset values: cnt=0, target[i]=active[i]=NEUTRAL_TICKS, wd[i]=0, pwm_out=0, frame_start=0, timeout=0.
- Frame counter cnt counts 0..FRAME_TICKS-1 and wraps while enable=1. While enable=0 it is held at 0. A frame tick is the cycle with cnt==FRAME_TICKS-1 and enable=1.
- Write: when wr_en=1 and wr_ch<NUM_CH, target[wr_ch] <= clamp(wr_data, MIN_TICKS, MAX_TICKS), wd[wr_ch] <= 0, timeout[wr_ch] <= 0. A write with wr_ch>=NUM_CH is ignored.
- Frame tick, per channel, evaluated in this order:
  - Watchdog: if TIMEOUT_FRAMES≠0 and no write to the channel occurs this cycle, wd increments, saturating at TIMEOUT_FRAMES. On reaching TIMEOUT_FRAMES, target <= NEUTRAL_TICKS and timeout <= 1.
  - Update: active <= next(active, target) using the target value held before this cycle.
- A write on the frame-tick cycle wins over the watchdog increment and the forced neutral. Its new target takes effect at the following frame tick.
- Widths are unsigned CNT_W. Comparisons are unsigned. The slew difference is computed without wrap.

## Timing
- pwm_out and frame_start are registered. frame_start=1 in the cycle after cnt==0 (enabled).
- pwm_out[i]=1 in the cycle after any enabled cycle with cnt<active[i]. The high time is exactly active[i] cycles, starting together with frame_start.
- Write-to-output latency: the value appears in the first frame that starts after the next frame tick. This is ≤1 frame plus 2 cycles.
- enable falling: pwm_out goes low on the next cycle, mid-pulse truncation is allowed, and cnt returns to 0. active and target are retained. enable rising: frame_start is asserted 1 cycle later.
- Reset asserted mid-frame: all outputs go low immediately (asynchronous).

## Configuration
- SERVO_SLEW_LIMIT_EN defined: next = target if |target−active|≤SLEW_STEP, else active±SLEW_STEP toward target.
- Not defined: next = target; SLEW_STEP is unused.

## Test plan
Overrides for all tests: FRAME_TICKS=1000, MIN=100, MAX=200, NEUTRAL=150, SLEW_STEP=10, TIMEOUT_FRAMES=3, NUM_CH=2.

- Reset then enable=1, no writes -> both channels give 150-cycle pulses every 1000 cycles. frame_start coincides with each rising edge.
- Write ch0=180 mid-frame, no macro -> the current frame is still 150 and the next frame is 180. ch1 is unchanged.
- Write 50, then 300, to ch1 -> pulses of 100, then 200 (clamped). A write with wr_ch=2 causes no change.
- SERVO_SLEW_LIMIT_EN, write ch0=200 -> successive frames of 160, 170, 180, 190, 200, then steady.
- No writes for 3 frame ticks after ch0=180 -> timeout[0]=1 and neutral 150 from the following update. A write of 120 clears timeout and gives 120.
- enable dropped at cnt=50 during a 180 pulse -> pwm_out is low the next cycle. On re-enable the pulse is a full 180 with frame_start.
